// File: rtl/gin_scatter_bus_pkg.sv
// gin_scatter_bus shared package: bus state encoding and broadcast tag.
// Default build widths are provided here when the surrounding project does
// not define NUMS_PE_COL, XID_BITS or DATA_BITS.
// Optional feature macro: GIN_BCAST_EN (all-ones tag addresses every slave).

`ifndef NUMS_PE_COL
`define NUMS_PE_COL 4
`endif

`ifndef XID_BITS
`define XID_BITS 4
`endif

`ifndef DATA_BITS
`define DATA_BITS 16
`endif

package gin_pkg;

   // Bus-level state: IDLE accepts a word, BUSY delivers it.
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } gin_state_e;

   // Tag value that addresses every slave when GIN_BCAST_EN is defined.
   localparam logic [`XID_BITS-1:0] BCAST_TAG = {`XID_BITS{1'b1}};

endpackage : gin_pkg

// File: rtl/gin_scatter_bus_if.sv
// gin_scatter_bus handshake bundle: master-side word offer and the
// per-slave valid/ready delivery side.
//   master : buffer-side producer of tagged words
//   slave  : PE-column consumers (one valid/ready bit per column)
//   bus    : the scatter bus itself

interface gin_scatter_bus_if #(
   parameter int NUMS_SLAVE = `NUMS_PE_COL,
   parameter int ID_SIZE    = `XID_BITS
);

   logic [ID_SIZE-1:0]    tag;
   logic                  master_valid;
   logic [`DATA_BITS-1:0] master_data;
   logic                  master_ready;
   logic [NUMS_SLAVE-1:0] slave_valid;
   logic [NUMS_SLAVE-1:0] slave_ready;
   logic [`DATA_BITS-1:0] slave_data;

   modport master (
      output tag,
      output master_valid,
      output master_data,
      input  master_ready
   );

   modport slave (
      input  slave_valid,
      input  slave_data,
      output slave_ready
   );

   modport bus (
      input  tag,
      input  master_valid,
      input  master_data,
      output master_ready,
      output slave_valid,
      input  slave_ready,
      output slave_data
   );

endinterface : gin_scatter_bus_if

// File: rtl/gin_multicast_target.sv
// gin_multicast_target: one PE-column slave of the scatter bus.
// Holds the column ID (one stage of the ID scan chain), compares it with the
// incoming tag, and owns the pending bit for this column's handshake.
// Optional feature macro: GIN_BCAST_EN (all-ones tag matches regardless of ID).

module gin_multicast_target #(
   parameter int ID_SIZE = `XID_BITS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               set_id,
   input  logic [ID_SIZE-1:0] id_in,
   output logic [ID_SIZE-1:0] id_out,
   input  logic [ID_SIZE-1:0] tag,
   input  logic               accept,
   input  logic               busy,
   input  logic               slave_ready,
   output logic               slave_valid,
   output logic               pending_next
);

   logic [ID_SIZE-1:0] id_q;
   logic [ID_SIZE-1:0] id_d;
   logic               pending_q;
   logic               pending_d;
   logic               match;

   // Next-state for the ID stage and pending bit, plus the tag compare.
   // NOTE: every output of this block gets a default first, so no path leaves
   // a variable unassigned and no latch is inferred.
   always_comb begin
      id_d      = id_q;
      pending_d = pending_q;
      match     = (id_q == tag);
`ifdef GIN_BCAST_EN
      match     = match | (tag == {ID_SIZE{1'b1}});
`endif
      if (set_id) begin
         id_d = id_in;
      end
      // The compare uses id_q, so an accept in the same cycle as a shift
      // sees the IDs from before the shift.
      if (accept) begin
         pending_d = match;
      end else if (busy && pending_q && slave_ready) begin
         pending_d = 1'b0;
      end
   end

   // ID register and pending bit, cleared by synchronous active-low reset.
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values of its neighbours in the scan chain.
   always_ff @(posedge clk) begin
      if (!rst) begin
         id_q      <= '0;
         pending_q <= 1'b0;
      end else begin
         id_q      <= id_d;
         pending_q <= pending_d;
      end
   end

   assign id_out       = id_q;
   assign slave_valid  = busy & pending_q;
   assign pending_next = pending_d;

endmodule : gin_multicast_target

// File: rtl/gin_scatter_bus.sv
// gin_scatter_bus: single-master, multi-slave multicast scatter bus.
// One tagged word is captured into a one-entry buffer and offered to every
// slave whose scanned-in ID matches the tag; the master is released only once
// every targeted slave has taken the word.
// Optional feature macro: GIN_BCAST_EN (all-ones tag broadcasts to all slaves).

module gin_scatter_bus
   import gin_pkg::*;
#(
   parameter int NUMS_SLAVE = `NUMS_PE_COL,
   parameter int ID_SIZE    = `XID_BITS
) (
   input  logic               clk,
   input  logic               rst,
   gin_scatter_bus_if.bus     bus_if,
   input  logic               set_id,
   input  logic [ID_SIZE-1:0] ID_scan_in,
   output logic [ID_SIZE-1:0] ID_scan_out
);

   gin_state_e             state_q;
   gin_state_e             state_d;
   logic [`DATA_BITS-1:0]  data_q;
   logic [`DATA_BITS-1:0]  data_d;
   logic                   accept;
   logic                   busy;
   logic [NUMS_SLAVE-1:0]  pending_d;
   logic [NUMS_SLAVE-1:0]  slave_valid;
   logic [NUMS_SLAVE:0][ID_SIZE-1:0] id_chain;

   assign busy        = (state_q == BUSY);
   assign accept      = (state_q == IDLE) && bus_if.master_valid;
   assign id_chain[0] = ID_scan_in;

   // One target per slave; the ID chain threads through them in index order,
   // so the first value shifted in ends up in the last slave.
   for (genvar i = 0; i < NUMS_SLAVE; i++) begin : g_target
      gin_multicast_target #(
         .ID_SIZE (ID_SIZE)
      ) u_target (
         .clk          (clk),
         .rst          (rst),
         .set_id       (set_id),
         .id_in        (id_chain[i]),
         .id_out       (id_chain[i+1]),
         .tag          (bus_if.tag),
         .accept       (accept),
         .busy         (busy),
         .slave_ready  (bus_if.slave_ready[i]),
         .slave_valid  (slave_valid[i]),
         .pending_next (pending_d[i])
      );
   end

   // Bus FSM next-state and word capture: leave IDLE only for a word with at
   // least one target, leave BUSY once no target is left pending.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      unique case (state_q)
         IDLE: begin
            if (bus_if.master_valid) begin
               // An untargeted word is still consumed; it simply never leaves.
               data_d = bus_if.master_data;
               if (|pending_d) begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            if (~|pending_d) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register and word buffer under synchronous active-low reset.
   // NOTE: data_q is reset even though its value only matters under
   // slave_valid, because slave_data must never be X after reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   // master_ready decodes the state register only: no path from slave_ready.
   assign bus_if.master_ready = (state_q == IDLE);
   assign bus_if.slave_valid  = slave_valid;
   assign bus_if.slave_data   = data_q;
   assign ID_scan_out         = id_chain[NUMS_SLAVE];

endmodule : gin_scatter_bus

// File: tb/tb_gin_scatter_bus.sv
// Self-checking bench for gin_scatter_bus: directed scenarios followed by
// randomized traffic, all compared every cycle against a transaction-level
// reference model (an array of IDs, a set of slaves still owed the word).

module tb_gin_scatter_bus;
   import gin_pkg::*;

   localparam int NS  = `NUMS_PE_COL;
   localparam int IDW = `XID_BITS;
   localparam int DW  = `DATA_BITS;
`ifdef GIN_BCAST_EN
   localparam bit BCAST = 1'b1;
`else
   localparam bit BCAST = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           set_id = 1'b0;
   logic [IDW-1:0] scan_in = '0;
   logic [IDW-1:0] scan_out;

   gin_scatter_bus_if #(.NUMS_SLAVE(NS), .ID_SIZE(IDW)) bus_if ();

   gin_scatter_bus #(
      .NUMS_SLAVE (NS),
      .ID_SIZE    (IDW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus_if      (bus_if),
      .set_id      (set_id),
      .ID_scan_in  (scan_in),
      .ID_scan_out (scan_out)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: slave IDs, whether a word is in flight, which slaves
   // are still owed it, and the last word accepted.
   int            m_id   [NS];
   bit            m_owed [NS];
   bit            m_busy;
   logic [DW-1:0] m_data;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [NS-1:0] m_valid();
      logic [NS-1:0] v;
      v = '0;
      for (int i = 0; i < NS; i++) v[i] = m_busy && m_owed[i];
      return v;
   endfunction

   // Apply one clock edge's worth of the bus rules to the model.
   task automatic model_edge();
      int old_id [NS];
      bit any;
      if (!rst) begin
         m_busy = 1'b0;
         m_data = '0;
         for (int i = 0; i < NS; i++) begin
            m_id[i]   = 0;
            m_owed[i] = 1'b0;
         end
      end else begin
         old_id = m_id;
         any    = 1'b0;
         if (!m_busy) begin
            if (bus_if.master_valid) begin
               m_data = bus_if.master_data;
               for (int i = 0; i < NS; i++) begin
                  m_owed[i] = (old_id[i] == int'(bus_if.tag)) ||
                              (BCAST && (bus_if.tag == BCAST_TAG));
                  any = any | m_owed[i];
               end
               m_busy = any;
            end
         end else begin
            for (int i = 0; i < NS; i++) begin
               if (m_owed[i] && bus_if.slave_ready[i]) m_owed[i] = 1'b0;
               any = any | m_owed[i];
            end
            m_busy = any;
         end
         if (set_id) begin
            for (int i = NS - 1; i > 0; i--) m_id[i] = old_id[i-1];
            m_id[0] = int'(scan_in);
         end
      end
   endtask

   // One clock: update the model at the edge, compare all outputs mid-cycle.
   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("master_ready", 32'(bus_if.master_ready), 32'(!m_busy));
      check("slave_valid", 32'(bus_if.slave_valid), 32'(m_valid()));
      check("slave_data", 32'(bus_if.slave_data), 32'(m_data));
      check("id_scan_out", 32'(scan_out), 32'(m_id[NS-1]));
   endtask

   // Shift in a full set of IDs so that slave i ends up holding ids[i].
   task automatic load_ids(input int ids [NS]);
      set_id = 1'b1;
      for (int i = NS - 1; i >= 0; i--) begin
         scan_in = IDW'(ids[i]);
         cycle();
      end
      set_id = 1'b0;
   endtask

   task automatic offer(input logic [IDW-1:0] t, input logic [DW-1:0] d);
      bus_if.master_valid = 1'b1;
      bus_if.tag          = t;
      bus_if.master_data  = d;
      cycle();
      bus_if.master_valid = 1'b0;
   endtask

   initial begin
      int ids_a [NS];
      ids_a = '{0, 1, 1, 2};

      bus_if.master_valid = 1'b0;
      bus_if.tag          = '0;
      bus_if.master_data  = '0;
      bus_if.slave_ready  = '0;

      // Reset state.
      cycle();
      cycle();
      check("rst_master_ready", 32'(bus_if.master_ready), 32'd1);
      check("rst_slave_valid", 32'(bus_if.slave_valid), 32'd0);
      check("rst_slave_data", 32'(bus_if.slave_data), 32'd0);
      check("rst_scan_out", 32'(scan_out), 32'd0);
      rst = 1'b1;

      // Scan chain: shift 3,2,1,0; first value lands in the last slave.
      set_id = 1'b1;
      for (int v = 3; v >= 0; v--) begin
         scan_in = IDW'(v);
         cycle();
      end
      set_id = 1'b0;
      check("scan_after4", 32'(scan_out), 32'd3);

      // Multicast to slaves 1 and 2, both ready at once.
      load_ids(ids_a);
      bus_if.slave_ready = '1;
      offer(IDW'(1), DW'(16'h00A5));
      check("mc1_valid", 32'(bus_if.slave_valid), 32'b0110);
      check("mc1_data", 32'(bus_if.slave_data), 32'h00A5);
      check("mc1_busy_ready", 32'(bus_if.master_ready), 32'd0);
      cycle();
      check("mc1_release", 32'(bus_if.master_ready), 32'd1);
      check("mc1_idle_valid", 32'(bus_if.slave_valid), 32'd0);

      // Slave 1 immediately, slave 2 three cycles later.
      bus_if.slave_ready = 4'b0010;
      offer(IDW'(1), DW'(16'h003C));
      check("mc2_valid0", 32'(bus_if.slave_valid), 32'b0110);
      cycle();
      check("mc2_valid1", 32'(bus_if.slave_valid), 32'b0100);
      bus_if.slave_ready = 4'b0000;
      cycle();
      check("mc2_valid2", 32'(bus_if.slave_valid), 32'b0100);
      cycle();
      check("mc2_valid3", 32'(bus_if.slave_valid), 32'b0100);
      check("mc2_hold", 32'(bus_if.master_ready), 32'd0);
      bus_if.slave_ready = 4'b0100;
      cycle();
      check("mc2_release", 32'(bus_if.master_ready), 32'd1);

      // No matching ID: word consumed and dropped.
      bus_if.slave_ready = '0;
      offer(IDW'(7), DW'(16'h0077));
      check("nomatch_valid", 32'(bus_if.slave_valid), 32'd0);
      check("nomatch_ready", 32'(bus_if.master_ready), 32'd1);

      // All-ones tag: broadcast only when the feature is enabled.
      offer(BCAST_TAG, DW'(16'h00BB));
      check("bcast_valid", 32'(bus_if.slave_valid), BCAST ? 32'b1111 : 32'd0);
      bus_if.slave_ready = '1;
      cycle();

      // Shift coinciding with accept: compare uses pre-shift IDs.
      bus_if.slave_ready = '0;
      set_id  = 1'b1;
      scan_in = IDW'(3);
      offer(IDW'(2), DW'(16'h0042));
      set_id  = 1'b0;
      check("shift_accept_valid", 32'(bus_if.slave_valid), 32'b1000);
      bus_if.slave_ready = '1;
      cycle();

      // Reset in the middle of BUSY discards the pending delivery.
      load_ids(ids_a);
      bus_if.slave_ready = '0;
      offer(IDW'(1), DW'(16'h0055));
      check("midrst_busy_valid", 32'(bus_if.slave_valid), 32'b0110);
      rst = 1'b0;
      cycle();
      rst = 1'b1;
      check("midrst_valid", 32'(bus_if.slave_valid), 32'd0);
      check("midrst_ready", 32'(bus_if.master_ready), 32'd1);
      check("midrst_scan", 32'(scan_out), 32'd0);
      set_id  = 1'b1;
      scan_in = '0;
      for (int i = 0; i < NS; i++) cycle();
      set_id = 1'b0;

      // Randomized traffic against the model; master holds tag/data while
      // its word is waiting to be accepted.
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 63) != 0);
         if (!m_busy) begin
            bus_if.master_valid = $urandom_range(0, 1) == 1;
            bus_if.tag = ($urandom_range(0, 7) == 0) ? BCAST_TAG : IDW'($urandom_range(0, 3));
            bus_if.master_data = DW'($urandom);
         end
         bus_if.slave_ready = NS'($urandom);
         set_id  = ($urandom_range(0, 5) == 0);
         scan_in = IDW'($urandom_range(0, 3));
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_gin_scatter_bus
